// File: rtl/mm_systolic_driver_if.sv
// Job, result and peripheral-bus signals of the systolic accelerator driver.
// master = the driver; slave = job source, result consumer and peripheral together.
interface mm_systolic_driver_if #(
    parameter int unsigned WIDTH = 32
);
    // Both job and result channels transfer on a rising edge where valid && ready.
    // valid stays high and its payload stays stable until that edge. ready may depend on state only.
    logic             job_valid;
    logic             job_ready;
    logic [WIDTH-1:0] job_north0;
    logic [WIDTH-1:0] job_north1;
    logic [WIDTH-1:0] job_west0;
    logic [WIDTH-1:0] job_west1;

    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_00;
    logic [31:0]      res_01;
    logic [31:0]      res_10;
    logic [31:0]      res_11;
    logic             res_timeout;
    logic             busy;

    logic [3:0]       wen;
    logic [21:0]      addr;
    logic [31:0]      wdata;
    logic [31:0]      rdata;

    modport master (
        input  job_valid, job_north0, job_north1, job_west0, job_west1, res_ready, rdata,
        output job_ready, res_valid, res_00, res_01, res_10, res_11, res_timeout, busy,
        output wen, addr, wdata
    );

    modport slave (
        output job_valid, job_north0, job_north1, job_west0, job_west1, res_ready, rdata,
        input  job_ready, res_valid, res_00, res_01, res_10, res_11, res_timeout, busy,
        input  wen, addr, wdata
    );
endinterface

// File: rtl/mm_systolic_driver.sv
// Runs one 2x2 multiply job on the memory-mapped systolic array: load operands,
// start, poll STATUS, read back the four result words and hand them to the consumer.
module mm_systolic_driver #(
    parameter int unsigned WIDTH         = 32,
    parameter logic [31:0] CTRL_CLEAR    = 32'h0000_0001,
    parameter logic [31:0] CTRL_RUN      = 32'h0001_0100,
    parameter int unsigned TIMEOUT_POLLS = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    mm_systolic_driver_if.master bus,
    output logic [3:0]           dbg_state_o
);
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_WR_CLR  = 4'd1;
    localparam logic [3:0] S_WR_N0   = 4'd2;
    localparam logic [3:0] S_WR_N1   = 4'd3;
    localparam logic [3:0] S_WR_W0   = 4'd4;
    localparam logic [3:0] S_WR_W1   = 4'd5;
    localparam logic [3:0] S_WR_RUN  = 4'd6;
    localparam logic [3:0] S_POLL_A  = 4'd7;
    localparam logic [3:0] S_POLL_B  = 4'd8;
    localparam logic [3:0] S_RD_A    = 4'd9;
    localparam logic [3:0] S_RD_B    = 4'd10;
    localparam logic [3:0] S_WR_STOP = 4'd11;
    localparam logic [3:0] S_OUT     = 4'd12;

    localparam int unsigned CNT_RAW = $clog2(TIMEOUT_POLLS + 1);
    localparam int unsigned CNT_W   = (CNT_RAW > 10) ? CNT_RAW : 10;
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_POLLS);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] poll_cnt_q, poll_cnt_d, poll_cnt_inc;
    logic [1:0]       idx_q, idx_d;
    logic             timeout_q, timeout_d;
    logic [31:0]      res_q [4];
    logic [31:0]      res_d [4];
    logic [WIDTH-1:0] n0_q, n1_q, w0_q, w1_q;

    logic             job_ready;
    logic             job_accept;
    logic             bus_wr;
    logic [7:0]       reg_idx;
    logic [31:0]      wr_data;

    // Ready is also masked by reset so no job is taken while reset is held.
    assign job_ready    = (state_q == S_IDLE) && !reset;
    assign job_accept   = bus.job_valid && job_ready;
    assign poll_cnt_inc = (poll_cnt_q == '1) ? poll_cnt_q : poll_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        poll_cnt_d = poll_cnt_q;
        idx_d      = idx_q;
        timeout_d  = timeout_q;
        res_d      = res_q;
        case (state_q)
            S_IDLE: begin
                if (job_accept) begin
                    state_d    = S_WR_CLR;
                    poll_cnt_d = '0;
                    timeout_d  = 1'b0;
                end
            end
            S_WR_CLR: state_d = S_WR_N0;
            S_WR_N0:  state_d = S_WR_N1;
            S_WR_N1:  state_d = S_WR_W0;
            S_WR_W0:  state_d = S_WR_W1;
            S_WR_W1:  state_d = S_WR_RUN;
            S_WR_RUN: state_d = S_POLL_A;
            S_POLL_A: state_d = S_POLL_B;
            S_POLL_B: begin
                if (bus.rdata[0]) begin
                    state_d = S_RD_A;
                    idx_d   = 2'd0;
                end else begin
                    poll_cnt_d = poll_cnt_inc;
                    if (poll_cnt_inc >= TO_LIM) begin
                        state_d   = S_WR_STOP;
                        timeout_d = 1'b1;
                        for (int i = 0; i < 4; i++) res_d[i] = '0;
                    end else begin
                        state_d = S_POLL_A;
                    end
                end
            end
            S_RD_A: state_d = S_RD_B;
            S_RD_B: begin
                res_d[idx_q] = bus.rdata;
                if (idx_q == 2'd3) begin
                    state_d = S_WR_STOP;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_RD_A;
                end
            end
            S_WR_STOP: state_d = S_OUT;
            S_OUT: begin
                if (bus.res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus signals decode straight from the registered state; a read holds its address for both cycles.
    always_comb begin
        bus_wr  = 1'b0;
        reg_idx = 8'h00;
        wr_data = 32'h0;
        case (state_q)
            S_WR_CLR: begin bus_wr = 1'b1; wr_data = CTRL_CLEAR; end
            S_WR_N0:  begin bus_wr = 1'b1; reg_idx = 8'h02; wr_data = 32'(n0_q); end
            S_WR_N1:  begin bus_wr = 1'b1; reg_idx = 8'h03; wr_data = 32'(n1_q); end
            S_WR_W0:  begin bus_wr = 1'b1; reg_idx = 8'h04; wr_data = 32'(w0_q); end
            S_WR_W1:  begin bus_wr = 1'b1; reg_idx = 8'h05; wr_data = 32'(w1_q); end
            S_WR_RUN: begin bus_wr = 1'b1; wr_data = CTRL_RUN; end
            S_POLL_A, S_POLL_B: reg_idx = 8'h01;
            S_RD_A, S_RD_B:     reg_idx = 8'h06 + {6'h00, idx_q};
            S_WR_STOP: bus_wr = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            poll_cnt_q <= '0;
            idx_q      <= '0;
            timeout_q  <= 1'b0;
            for (int i = 0; i < 4; i++) res_q[i] <= '0;
            n0_q       <= '0;
            n1_q       <= '0;
            w0_q       <= '0;
            w1_q       <= '0;
        end else begin
            state_q    <= state_d;
            poll_cnt_q <= poll_cnt_d;
            idx_q      <= idx_d;
            timeout_q  <= timeout_d;
            for (int i = 0; i < 4; i++) res_q[i] <= res_d[i];
            if (job_accept) begin
                n0_q <= bus.job_north0;
                n1_q <= bus.job_north1;
                w0_q <= bus.job_west0;
                w1_q <= bus.job_west1;
            end
        end
    end

    assign bus.job_ready   = job_ready;
    assign bus.res_valid   = (state_q == S_OUT);
    assign bus.res_00      = res_q[0];
    assign bus.res_01      = res_q[1];
    assign bus.res_10      = res_q[2];
    assign bus.res_11      = res_q[3];
    assign bus.res_timeout = timeout_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.wen         = bus_wr ? 4'hF : 4'h0;
    assign bus.addr        = {14'h0000, reg_idx};
    assign bus.wdata       = wr_data;
    assign dbg_state_o     = state_q;
endmodule
